// File: rtl/conv_mac_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_pkg
// Description : Shared constants and helpers for the convolution multiply
//               stage: default tap count and operand widths, and the
//               ceil(log2) helper that sizes the adder-tree result.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

  localparam int CONV_TAPS   = 9;
  localparam int CONV_PIX_W  = 8;
  localparam int CONV_COEF_W = 8;

  // ceil(log2(taps)); returns 0 for taps=1. Covers taps up to 64.
  function automatic int clog2_taps(input int taps);
    int r;
    r = 0;
    for (int k = 0; k < 6; k++) begin
      if ((1 << k) < taps) r = k + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_mac_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : conv_mac_stage_if
// Description : Input (window + coefficients) and output (products, coef,
//               sum) valid/ready bundles of the multiply stage.
//   master : producer of input beats / consumer of output beats
//   slave  : the multiply stage itself
//   in_valid/in_ready/pix_in/coef_in  - input beat
//   out_valid/out_ready/coef_out/prod_out/sum_out - output beat
// Revision    : 1.0 - initial release
// ============================================================================
interface conv_mac_stage_if #(
  parameter int TAPS   = 9,
  parameter int PIX_W  = 8,
  parameter int COEF_W = 8
);
  import conv_pkg::*;

  localparam int PROD_W = PIX_W + COEF_W;
  localparam int SUM_W  = PROD_W + clog2_taps(TAPS);

  logic                     in_valid;
  logic                     in_ready;
  logic [TAPS*PIX_W-1:0]    pix_in;
  logic [TAPS*COEF_W-1:0]   coef_in;
  logic                     out_valid;
  logic                     out_ready;
  logic [TAPS*COEF_W-1:0]   coef_out;
  logic [TAPS*PROD_W-1:0]   prod_out;
  logic [SUM_W-1:0]         sum_out;

  modport master (
    output in_valid, pix_in, coef_in, out_ready,
    input  in_ready, out_valid, coef_out, prod_out, sum_out
  );

  modport slave (
    input  in_valid, pix_in, coef_in, out_ready,
    output in_ready, out_valid, coef_out, prod_out, sum_out
  );

endinterface
`default_nettype wire

// File: rtl/conv_mac_stage_mult.sv
`default_nettype none
// ============================================================================
// Module      : conv_mult
// Description : One registered PIX_W x COEF_W multiplier with load enable.
//               Pixel is unsigned; coefficient is unsigned or two's
//               complement (COEF_SIGNED). Result is exact in PIX_W+COEF_W.
//   clk, rst (async, active-low), i_en (load), i_pix, i_coef, o_prod
// Revision    : 1.0 - initial release
// ============================================================================
module conv_mult
  import conv_pkg::*;
#(
  parameter int PIX_W       = CONV_PIX_W,
  parameter int COEF_W      = CONV_COEF_W,
  parameter int COEF_SIGNED = 0
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     i_en,
  input  wire logic [PIX_W-1:0]         i_pix,
  input  wire logic [COEF_W-1:0]        i_coef,
  output logic      [PIX_W+COEF_W-1:0]  o_prod
);

  localparam int PROD_W = PIX_W + COEF_W;

  logic [PROD_W-1:0] w_pix_ext;
  logic [PROD_W-1:0] w_coef_ext;
  logic [PROD_W-1:0] w_prod;
  logic [PROD_W-1:0] r_prod;

  // Both operands are extended to the full result width; the low PROD_W
  // bits of that product are the exact two's complement result, since
  // the true product always fits in PROD_W.
  assign w_pix_ext = {{COEF_W{1'b0}}, i_pix};

  generate
    if (COEF_SIGNED != 0) begin : g_coef_sext
      assign w_coef_ext = {{PIX_W{i_coef[COEF_W-1]}}, i_coef};
    end else begin : g_coef_zext
      assign w_coef_ext = {{PIX_W{1'b0}}, i_coef};
    end
  endgenerate

  assign w_prod = w_pix_ext * w_coef_ext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prod <= '0;
    end else if (i_en) begin
      r_prod <= w_prod;
    end
  end

  assign o_prod = r_prod;

endmodule
`default_nettype wire

// File: rtl/conv_mac_stage.sv
`default_nettype none
// ============================================================================
// Module      : conv_mac_stage
// Description : Stall-capable multiply stage of the convolution datapath.
//               S1 registers the window and coefficients, S2 registers the
//               per-tap products, optional S3 registers the adder-tree sum.
//               Bubble-collapsing valid/ready between every stage.
//   Build macro CONV_MAC_SUM_EN : adds S3 and a live sum_out (latency 3);
//               undefined gives latency 2 and sum_out tied to 0.
//   clk  : rising-edge clock
//   rst  : asynchronous, active-low reset
//   bus  : conv_mac_stage_if.slave (input beat in, product beat out)
// Revision    : 1.0 - initial release
// ============================================================================
module conv_mac_stage
  import conv_pkg::*;
#(
  parameter int TAPS        = CONV_TAPS,
  parameter int PIX_W       = CONV_PIX_W,
  parameter int COEF_W      = CONV_COEF_W,
  parameter int COEF_SIGNED = 0
) (
  input  wire logic        clk,
  input  wire logic        rst,
  conv_mac_stage_if.slave  bus
);

  localparam int PROD_W = PIX_W + COEF_W;
  localparam int SUM_W  = PROD_W + clog2_taps(TAPS);

  logic                   r_v1;
  logic [TAPS*PIX_W-1:0]  r_pix1;
  logic [TAPS*COEF_W-1:0] r_coef1;
  logic                   r_v2;
  logic [TAPS*COEF_W-1:0] r_coef2;
  logic [TAPS*PROD_W-1:0] w_prod2;
  logic                   w_load1;
  logic                   w_load2;
  logic                   w_down2;

  // Load chain: a stage may load when empty or when its successor moves.
  assign w_load2     = ~r_v2 | w_down2;
  assign w_load1     = ~r_v1 | w_load2;
  assign bus.in_ready = w_load1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v1    <= 1'b0;
      r_pix1  <= '0;
      r_coef1 <= '0;
    end else if (w_load1) begin
      r_v1    <= bus.in_valid;
      r_pix1  <= bus.pix_in;
      r_coef1 <= bus.coef_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v2    <= 1'b0;
      r_coef2 <= '0;
    end else if (w_load2) begin
      r_v2    <= r_v1;
      r_coef2 <= r_coef1;
    end
  end

  // The multipliers hold the S2 product registers; they share S2's load.
  generate
    for (genvar i = 0; i < TAPS; i++) begin : g_tap
      conv_mult #(
        .PIX_W       (PIX_W),
        .COEF_W      (COEF_W),
        .COEF_SIGNED (COEF_SIGNED)
      ) u_mult (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_load2),
        .i_pix  (r_pix1[i*PIX_W +: PIX_W]),
        .i_coef (r_coef1[i*COEF_W +: COEF_W]),
        .o_prod (w_prod2[i*PROD_W +: PROD_W])
      );
    end
  endgenerate

`ifdef CONV_MAC_SUM_EN
  localparam int NLEAF = 1 << clog2_taps(TAPS);

  logic                   r_v3;
  logic [TAPS*COEF_W-1:0] r_coef3;
  logic [TAPS*PROD_W-1:0] r_prod3;
  logic [SUM_W-1:0]       r_sum3;
  logic [SUM_W-1:0]       w_sum;
  logic                   w_load3;

  assign w_load3 = ~r_v3 | bus.out_ready;
  assign w_down2 = w_load3;

  // Balanced tree in heap layout: leaves at [NLEAF..2*NLEAF-1], padded
  // with zeros past TAPS; node n = child 2n + child 2n+1; root at [1].
  always_comb begin
    logic [SUM_W-1:0] w_tree [2*NLEAF];
    for (int n = 0; n < 2*NLEAF; n++) begin
      w_tree[n] = '0;
    end
    for (int i = 0; i < TAPS; i++) begin
      if (COEF_SIGNED != 0) begin
        w_tree[NLEAF+i] = SUM_W'($signed(w_prod2[i*PROD_W +: PROD_W]));
      end else begin
        w_tree[NLEAF+i] = SUM_W'(w_prod2[i*PROD_W +: PROD_W]);
      end
    end
    for (int n = NLEAF - 1; n >= 1; n--) begin
      w_tree[n] = w_tree[2*n] + w_tree[2*n+1];
    end
    w_sum = w_tree[1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v3    <= 1'b0;
      r_coef3 <= '0;
      r_prod3 <= '0;
      r_sum3  <= '0;
    end else if (w_load3) begin
      r_v3    <= r_v2;
      r_coef3 <= r_coef2;
      r_prod3 <= w_prod2;
      r_sum3  <= w_sum;
    end
  end

  assign bus.out_valid = r_v3;
  assign bus.coef_out  = r_coef3;
  assign bus.prod_out  = r_prod3;
  assign bus.sum_out   = r_sum3;
`else
  assign w_down2       = bus.out_ready;
  assign bus.out_valid = r_v2;
  assign bus.coef_out  = r_coef2;
  assign bus.prod_out  = w_prod2;
  assign bus.sum_out   = {SUM_W{1'b0}};
`endif

endmodule
`default_nettype wire
